rat_unit: RTL and testbench

RAT_UNIT -- requirements
Module: rat_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/rat_src_lookup.sv | 24 ++
 rtl/rat_unit.sv | 100 ++++++++++
 tb/tb_rat_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide parameters and records used by the rename stage.
// The RAT entry record lives here so that other pipeline stages can reuse it.
package cpu_pkg;

  localparam int ARCH_REGS = 32;
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int TAG_W     = 5;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

endpackage

// File: rtl/rat_src_lookup.sv
// Resolves one rename source against its RAT entry.
// A result appearing on the CDB this cycle is bypassed straight through.
module rat_src_lookup
  import cpu_pkg::*;
(
  input  logic [AREG_W-1:0] areg_i,
  input  rat_entry_t        entry_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  output logic              ready_o,
  output logic [TAG_W-1:0]  tag_o
);

  // r0 and unmapped registers read straight from the ARF, so they report tag 0.
  always_comb begin
    ready_o = 1'b1;
    tag_o   = '0;
    if ((areg_i != '0) && entry_i.busy) begin
      tag_o   = entry_i.tag;
      ready_o = entry_i.ready | (cdb_valid_i & (cdb_tag_i == entry_i.tag));
    end
  end

endmodule

// File: rtl/rat_unit.sv
// Register alias table: maps each architectural register to its in-flight ROB producer.
// Sources are looked up combinationally from the pre-update table; all state changes land on the clock edge.
module rat_unit #(
  parameter int ARCH_REGS = cpu_pkg::ARCH_REGS,
  parameter int AREG_W    = cpu_pkg::AREG_W,
  parameter int TAG_W     = cpu_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [AREG_W-1:0] rs,
  input  logic [AREG_W-1:0] rt,
  input  logic [AREG_W-1:0] rd,
  input  logic              has_dest,
  input  logic [TAG_W-1:0]  rob_tag_alloc,
  input  logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              commit_valid,
  input  logic [AREG_W-1:0] commit_areg,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic [TAG_W-1:0]  rs_tag_out,
  output logic [TAG_W-1:0]  rt_tag_out,
  output logic              rs_ready,
  output logic              rt_ready,
  output logic [TAG_W-1:0]  dest_rob_tag_out,
  output logic              issue_fire,
  output logic              stall
);

  import cpu_pkg::*;

  rat_entry_t [ARCH_REGS-1:0] table_q;
  rat_entry_t [ARCH_REGS-1:0] table_d;
  rat_entry_t                 rsEntry;
  rat_entry_t                 rtEntry;
  logic                       renameWrite;

  assign stall            = rst_n & issue_valid & (rob_full | flush);
  assign issue_fire       = rst_n & issue_valid & ~(rob_full | flush);
  assign dest_rob_tag_out = rob_tag_alloc;
  assign renameWrite      = issue_fire & has_dest & (rd != '0);

  // Hiding the table while in reset makes every source read as ready with tag 0.
  assign rsEntry = rst_n ? table_q[rs] : '0;
  assign rtEntry = rst_n ? table_q[rt] : '0;

  rat_src_lookup u_rs_lookup (
    .areg_i      (rs),
    .entry_i     (rsEntry),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .ready_o     (rs_ready),
    .tag_o       (rs_tag_out)
  );

  rat_src_lookup u_rt_lookup (
    .areg_i      (rt),
    .entry_i     (rtEntry),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .ready_o     (rt_ready),
    .tag_o       (rt_tag_out)
  );

  // Later statements override earlier ones, giving flush > rename > commit > CDB.
  // Commit only frees a mapping whose tag still matches, so a newer rename survives.
  always_comb begin
    table_d = table_q;
    for (int i = 1; i < ARCH_REGS; i++) begin
      if (cdb_valid && table_q[i].busy && (table_q[i].tag == cdb_tag)) begin
        table_d[i].ready = 1'b1;
      end
      if (commit_valid && (commit_areg == AREG_W'(i)) && table_q[i].busy &&
          (table_q[i].tag == commit_tag)) begin
        table_d[i].busy  = 1'b0;
        table_d[i].ready = 1'b0;
      end
      if (renameWrite && (rd == AREG_W'(i))) begin
        table_d[i].busy  = 1'b1;
        table_d[i].ready = 1'b0;
        table_d[i].tag   = rob_tag_alloc;
      end
      if (flush) begin
        table_d[i].busy  = 1'b0;
        table_d[i].ready = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_q <= '0;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: tb/tb_rat_unit.sv
// Self-checking bench for rat_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural table model.
module tb_rat_unit;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [AW-1:0] rs, rt, rd;
  logic          has_dest;
  logic [TW-1:0] rob_tag_alloc;
  logic          rob_full;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic          commit_valid;
  logic [AW-1:0] commit_areg;
  logic [TW-1:0] commit_tag;
  logic          flush;
  logic [TW-1:0] rs_tag_out, rt_tag_out, dest_rob_tag_out;
  logic          rs_ready, rt_ready, issue_fire, stall;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  bit          mBusy  [NR];
  bit          mReady [NR];
  bit [TW-1:0] mTag   [NR];

  rat_unit #(.ARCH_REGS(NR), .AREG_W(AW), .TAG_W(TW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid      (issue_valid),
    .rs               (rs),
    .rt               (rt),
    .rd               (rd),
    .has_dest         (has_dest),
    .rob_tag_alloc    (rob_tag_alloc),
    .rob_full         (rob_full),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .commit_valid     (commit_valid),
    .commit_areg      (commit_areg),
    .commit_tag       (commit_tag),
    .flush            (flush),
    .rs_tag_out       (rs_tag_out),
    .rt_tag_out       (rt_tag_out),
    .rs_ready         (rs_ready),
    .rt_ready         (rt_ready),
    .dest_rob_tag_out (dest_rob_tag_out),
    .issue_fire       (issue_fire),
    .stall            (stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected source resolution straight from the table rules.
  function automatic void expSrc(input logic [AW-1:0] r, output int rdy, output int tg);
    if (!rst_n || r == 0 || !mBusy[r]) begin
      rdy = 1;
      tg  = 0;
    end else begin
      tg  = mTag[r];
      rdy = (mReady[r] || (cdb_valid && cdb_tag == mTag[r])) ? 1 : 0;
    end
  endfunction

  // Model of the table's edge behaviour.
  always @(posedge clk) begin : model
    bit fire;
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin
        mBusy[r] = 0; mReady[r] = 0; mTag[r] = '0;
      end
    end else if (flush) begin
      for (int r = 0; r < NR; r++) begin
        mBusy[r] = 0; mReady[r] = 0;
      end
    end else begin
      fire = issue_valid && !rob_full;
      for (int r = 1; r < NR; r++) begin
        if (fire && has_dest && rd == r) begin
          mBusy[r] = 1; mReady[r] = 0; mTag[r] = rob_tag_alloc;
        end else if (commit_valid && commit_areg == r && mBusy[r] && mTag[r] == commit_tag) begin
          mBusy[r] = 0; mReady[r] = 0;
        end else if (cdb_valid && mBusy[r] && mTag[r] == cdb_tag) begin
          mReady[r] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int er, et;
    if (checkEn) begin
      expSrc(rs, er, et);
      checkOutput("rs_ready", rs_ready, er);
      checkOutput("rs_tag_out", rs_tag_out, et);
      expSrc(rt, er, et);
      checkOutput("rt_ready", rt_ready, er);
      checkOutput("rt_tag_out", rt_tag_out, et);
      checkOutput("stall", stall, (rst_n && issue_valid && (rob_full || flush)) ? 1 : 0);
      checkOutput("issue_fire", issue_fire, (rst_n && issue_valid && !(rob_full || flush)) ? 1 : 0);
      checkOutput("dest_rob_tag_out", dest_rob_tag_out, rob_tag_alloc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; issue_valid = 0; has_dest = 0; rs = '0; rt = '0; rd = '0;
    rob_tag_alloc = '0; rob_full = 0; cdb_valid = 0; cdb_tag = '0;
    commit_valid = 0; commit_areg = '0; commit_tag = '0; flush = 0;
  endtask

  task automatic issue(input int d, input int tag);
    idle();
    issue_valid   = 1;
    has_dest      = 1;
    rd            = AW'(d);
    rob_tag_alloc = TW'(tag);
  endtask

  task automatic applyStimulus();
    rst_n         = ($urandom_range(0, 79) != 0);
    issue_valid   = ($urandom_range(0, 9) < 6);
    has_dest      = ($urandom_range(0, 9) < 8);
    rs            = AW'($urandom_range(0, NR - 1));
    rt            = AW'($urandom_range(0, NR - 1));
    rd            = AW'($urandom_range(0, NR - 1));
    rob_tag_alloc = TW'($urandom);
    rob_full      = ($urandom_range(0, 9) == 0);
    flush         = ($urandom_range(0, 39) == 0);
    cdb_valid     = ($urandom_range(0, 1) == 1);
    cdb_tag       = $urandom_range(0, 1) ? mTag[$urandom_range(0, NR - 1)] : TW'($urandom);
    commit_valid  = ($urandom_range(0, 9) < 4);
    commit_areg   = AW'($urandom_range(0, NR - 1));
    commit_tag    = ($urandom_range(0, 9) < 6) ? mTag[commit_areg] : TW'($urandom);
  endtask

  initial begin
    idle();
    rst_n = 0; issue_valid = 1; rob_full = 1; rs = 3; rt = 9;
    repeat (2) tick();
    checkEn = 1;
    settle();
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_fire", issue_fire, 0);
    checkOutput("reset_rs_ready", rs_ready, 1);
    checkOutput("reset_rs_tag", rs_tag_out, 0);
    tick();

    idle(); rs = 3; rt = 4;
    settle();
    checkOutput("init_rs_ready", rs_ready, 1);
    checkOutput("init_rt_ready", rt_ready, 1);
    checkOutput("init_rs_tag", rs_tag_out, 0);
    checkOutput("init_rt_tag", rt_tag_out, 0);
    tick();

    issue(5, 9);
    settle();
    checkOutput("ren5_fire", issue_fire, 1);
    checkOutput("ren5_dest_tag", dest_rob_tag_out, 9);
    tick();
    idle(); rs = 5;
    settle();
    checkOutput("r5_pending_ready", rs_ready, 0);
    checkOutput("r5_pending_tag", rs_tag_out, 9);
    cdb_valid = 1; cdb_tag = 9;
    #1;
    checkOutput("r5_bypass_ready", rs_ready, 1);
    tick();
    idle(); rs = 5;
    settle();
    checkOutput("r5_table_ready", rs_ready, 1);
    checkOutput("r5_table_tag", rs_tag_out, 9);
    tick();

    issue(5, 9);
    tick();
    issue(5, 12);
    tick();
    idle(); commit_valid = 1; commit_areg = 5; commit_tag = 9; rs = 5;
    settle();
    checkOutput("r5_newer_tag", rs_tag_out, 12);
    tick();
    idle(); rs = 5;
    settle();
    checkOutput("stale_commit_ready", rs_ready, 0);
    checkOutput("stale_commit_tag", rs_tag_out, 12);
    commit_valid = 1; commit_areg = 5; commit_tag = 12;
    tick();
    idle(); rs = 5;
    settle();
    checkOutput("commit_free_ready", rs_ready, 1);
    checkOutput("commit_free_tag", rs_tag_out, 0);
    tick();

    issue(7, 1);
    tick();
    issue(7, 3); rs = 7;
    settle();
    checkOutput("self_ren_old_tag", rs_tag_out, 1);
    checkOutput("self_ren_old_ready", rs_ready, 0);
    tick();
    idle(); rs = 7;
    settle();
    checkOutput("self_ren_new_tag", rs_tag_out, 3);
    tick();

    issue(8, 20); rob_full = 1;
    settle();
    checkOutput("full_stall", stall, 1);
    checkOutput("full_fire", issue_fire, 0);
    tick();
    idle(); rs = 8;
    settle();
    checkOutput("full_no_write_ready", rs_ready, 1);
    checkOutput("full_no_write_tag", rs_tag_out, 0);
    tick();
    issue(0, 6);
    settle();
    checkOutput("r0_fire", issue_fire, 1);
    tick();
    idle(); rs = 0;
    settle();
    checkOutput("r0_ready", rs_ready, 1);
    checkOutput("r0_tag", rs_tag_out, 0);
    tick();

    for (int i = 1; i <= 10; i++) begin
      issue(i, 10 + i);
      tick();
    end
    idle(); rs = 10;
    settle();
    checkOutput("pre_flush_ready", rs_ready, 0);
    checkOutput("pre_flush_tag", rs_tag_out, 20);
    tick();
    issue(11, 2); flush = 1;
    settle();
    checkOutput("flush_stall", stall, 1);
    checkOutput("flush_fire", issue_fire, 0);
    tick();
    for (int i = 1; i <= 11; i++) begin
      idle(); rs = AW'(i); rt = AW'(12 - i);
      settle();
      checkOutput("post_flush_ready", rs_ready, 1);
      checkOutput("post_flush_tag", rs_tag_out, 0);
      tick();
    end

    repeat (3000) begin
      applyStimulus();
      tick();
    end

    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
